// File: rtl/mem_pkg.sv
// Shared memory-path definitions: size codes, buffer occupancy states and the byte-lane
// formatter used by the store path (and available to the load-path extenders for lane select).
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } occ_e;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

  // Replicate the significant low bits of the operand across all lanes so the memory only
  // needs the byte enables to pick the destination bytes.
  function automatic lane_t fmt_lane(input logic [1:0] size, input logic [1:0] a,
                                     input logic [31:0] d);
    lane_t r;
    r.wdata = d;
    r.be    = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        r.wdata = {4{d[7:0]}};
        r.be    = 4'b0001 << a;
      end
      SIZE_HALF: begin
        r.wdata = {2{d[15:0]}};
        r.be    = a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        r.wdata = d;
        r.be    = 4'b1111;
      end
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      SIZE_BYTE: m = 1'b0;
      SIZE_HALF: m = a[0];
      default:   m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// Pure combinational store formatter: size/address-low/operand -> lane-replicated data and
// byte enables.
module store_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o
);

  lane_t lane;

  always_comb begin
    lane    = fmt_lane(size_i, addr_lo_i, data_i);
    wdata_o = lane.wdata;
    be_o    = lane.be;
  end

endmodule

// File: rtl/store_narrow.sv
// MEM-stage store formatter with a 2-entry elastic buffer between EX/MEM and data memory.
// Define STORE_MISALIGN_TRAP_EN to trap misaligned half/word stores via the misalign port.
module store_narrow
  import mem_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_addr,
  input  logic [1:0]       in_size,
  input  logic [31:0]      in_data,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [AW-1:0]    mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
`ifdef STORE_MISALIGN_TRAP_EN
  output logic             misalign,
`endif
  output logic [CNT_W-1:0] store_count
);

  typedef struct packed {
    logic [AW-3:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } ent_t;

  occ_e             state_q, state_d;
  ent_t             head_q, head_d;
  ent_t             tail_q, tail_d;
  ent_t             new_ent;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fmt_wdata;
  logic [3:0]       fmt_be;
  logic             accept, push, drain, trap;

  store_lane_fmt u_fmt (
    .size_i    (in_size),
    .addr_lo_i (in_addr[1:0]),
    .data_i    (in_data),
    .wdata_o   (fmt_wdata),
    .be_o      (fmt_be)
  );

  assign new_ent = '{waddr: in_addr[AW-1:2], wdata: fmt_wdata, be: fmt_be};

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap = is_misaligned(in_size, in_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Ready and valid come straight from the occupancy register, so there is no comb path
  // from either side of the buffer to the other.
  assign in_ready  = (state_q != StTwo);
  assign mem_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~trap;
  assign drain     = mem_valid & mem_ready;

  assign mem_addr    = {head_q.waddr, 2'b00};
  assign mem_wdata   = head_q.wdata;
  assign mem_be      = head_q.be;
  assign store_count = count_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = drain ? count_q + CNT_W'(1) : count_q;
    case (state_q)
      StEmpty: begin
        if (push) begin
          head_d  = new_ent;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && drain) begin
          head_d = new_ent;
        end else if (push) begin
          tail_d  = new_ent;
          state_d = StTwo;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (drain) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept & trap;
    end
  end

  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: formatting, latency, backpressure, throughput, async reset
// and the misaligned-store behaviour of whichever build is compiled.
module tb_store_narrow;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic [31:0] in_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] store_count;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_total;
  int n_bad;

  store_narrow #(
    .AW    (32),
    .CNT_W (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_size     (in_size),
    .in_data     (in_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
`ifdef STORE_MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .store_count (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    in_valid = 1'b1;
    in_size  = size;
    in_addr  = addr;
    in_data  = data;
  endtask

  logic [31:0] tp_data [10];

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_size   = 2'b00;
    in_data   = '0;
    mem_ready = 1'b0;
    repeat (3) step();

    check_eq("rst_in_ready", 64'(in_ready), 64'h1);
    check_eq("rst_mem_valid", 64'(mem_valid), 64'h0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'h0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check_eq("rst_mem_be", 64'(mem_be), 64'h0);
    check_eq("rst_count", 64'(store_count), 64'h0);
`ifdef STORE_MISALIGN_TRAP_EN
    check_eq("rst_misalign", 64'(misalign), 64'h0);
`endif
    reset_n = 1'b1;
    step();

    // Byte store; output must not appear until the cycle after accept.
    drive(2'b00, 32'h0000_1003, 32'h1234_5678);
    #1;
    check_eq("byte_no_comb", 64'(mem_valid), 64'h0);
    step();
    in_valid = 1'b0;
    check_eq("byte_valid", 64'(mem_valid), 64'h1);
    check_eq("byte_wdata", 64'(mem_wdata), 64'h7878_7878);
    check_eq("byte_be", 64'(mem_be), 64'h8);
    check_eq("byte_addr", 64'(mem_addr), 64'h0000_1000);
    step();
    check_eq("byte_stall_hold", 64'(mem_wdata), 64'h7878_7878);
    mem_ready = 1'b1;
    step();
    check_eq("byte_drained", 64'(mem_valid), 64'h0);
    check_eq("byte_count", 64'(store_count), 64'h1);

    drive(2'b01, 32'h0000_2002, 32'hCAFE_BEEF);
    step();
    in_valid = 1'b0;
    check_eq("half_wdata", 64'(mem_wdata), 64'hBEEF_BEEF);
    check_eq("half_be", 64'(mem_be), 64'hC);
    check_eq("half_addr", 64'(mem_addr), 64'h0000_2000);
    step();

    drive(2'b10, 32'h0000_2000, 32'hCAFE_BEEF);
    step();
    in_valid = 1'b0;
    check_eq("word_wdata", 64'(mem_wdata), 64'hCAFE_BEEF);
    check_eq("word_be", 64'(mem_be), 64'hF);
    step();
    check_eq("word_count", 64'(store_count), 64'h3);

    // Backpressure: three back-to-back words with memory stalled.
    mem_ready = 1'b0;
    drive(2'b10, 32'h0000_0010, 32'hAAAA_0001);
    step();
    check_eq("bp_ready_one", 64'(in_ready), 64'h1);
    drive(2'b10, 32'h0000_0020, 32'hAAAA_0002);
    step();
    check_eq("bp_ready_two", 64'(in_ready), 64'h0);
    drive(2'b10, 32'h0000_0030, 32'hAAAA_0003);
    step();
    check_eq("bp_full_hold", 64'(in_ready), 64'h0);
    check_eq("bp_head_a", 64'(mem_wdata), 64'hAAAA_0001);
    check_eq("bp_head_a_addr", 64'(mem_addr), 64'h0000_0010);
    mem_ready = 1'b1;
    step();
    check_eq("bp_head_b", 64'(mem_wdata), 64'hAAAA_0002);
    check_eq("bp_ready_back", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check_eq("bp_head_c", 64'(mem_wdata), 64'hAAAA_0003);
    check_eq("bp_head_c_addr", 64'(mem_addr), 64'h0000_0030);
    step();
    check_eq("bp_empty", 64'(mem_valid), 64'h0);
    check_eq("bp_count", 64'(store_count), 64'h6);

    // Streaming: accept and drain every cycle while holding one entry.
    for (int i = 0; i < 10; i++) tp_data[i] = 32'h5000_0000 + 32'(i * 17);
    for (int i = 0; i < 10; i++) begin
      drive(2'b10, 32'h0000_4000, tp_data[i]);
      step();
      check_eq($sformatf("tp_ready_%0d", i), 64'(in_ready), 64'h1);
      check_eq($sformatf("tp_wdata_%0d", i), 64'(mem_wdata), 64'(tp_data[i]));
    end
    in_valid = 1'b0;
    step();
    check_eq("tp_empty", 64'(mem_valid), 64'h0);
    check_eq("tp_count", 64'(store_count), 64'd16);

    // Async reset while full: everything cleared immediately, nothing replayed.
    mem_ready = 1'b0;
    drive(2'b10, 32'h0000_5000, 32'h1111_1111);
    step();
    drive(2'b10, 32'h0000_5004, 32'h2222_2222);
    step();
    in_valid = 1'b0;
    check_eq("rst2_full", 64'(in_ready), 64'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst2_valid", 64'(mem_valid), 64'h0);
    check_eq("rst2_count", 64'(store_count), 64'h0);
    check_eq("rst2_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    check_eq("rst2_no_replay", 64'(mem_valid), 64'h0);
    check_eq("rst2_count_hold", 64'(store_count), 64'h0);

    // Misaligned word.
    drive(2'b10, 32'h0000_3001, 32'hDEAD_BEEF);
    step();
    in_valid = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    check_eq("mis_pulse", 64'(misalign), 64'h1);
    check_eq("mis_no_valid", 64'(mem_valid), 64'h0);
    step();
    check_eq("mis_pulse_end", 64'(misalign), 64'h0);
    check_eq("mis_count", 64'(store_count), 64'h0);
`else
    check_eq("mis_valid", 64'(mem_valid), 64'h1);
    check_eq("mis_be", 64'(mem_be), 64'hF);
    check_eq("mis_addr", 64'(mem_addr), 64'h0000_3000);
    check_eq("mis_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    step();
    check_eq("mis_count", 64'(store_count), 64'h1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
